point_normalizer: RTL and testbench
===================================

Name: point_normalizer

Overview:
- Converts a homogeneous clip-space point (x, y, z, w) into a screen pixel coordinate.
- Performs the perspective divide (x/w, y/w, z/w) in signed fixed point, then a viewport transform onto a SCREEN_W x SCREEN_H raster.
- Sits between the vertex transform stage and the rasterizer in the graphics pipeline.
- Iterative: accepts one point at a time and reports completion with a one-cycle valid pulse.

Parameters:
- CORDW, 16: width of all point and pixel coordinates.
- FRAC, 8: fractional bits of the signed point fixed-point format (Q(CORDW-FRAC).FRAC). 1.0 = 256.
- SCREEN_W, 640: raster width in pixels.
- SCREEN_H, 480: raster height in pixels.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- io_aresetn  in  1  asynchronous, active-low reset.
- io_writeEnable  in  1  request to start a new point; accepted only when io_ready=1.
- io_point_x  in  CORDW  signed fixed-point x.
- io_point_y  in  CORDW  signed fixed-point y.
- io_point_z  in  CORDW  signed fixed-point z.
- io_point_w  in  CORDW  signed fixed-point w.
- io_ready  out  1  high in IDLE.
- io_pixelValid  out  1  one-cycle pulse when results update.
- io_pixel_x  out  CORDW  unsigned pixel column, 0..SCREEN_W-1.
- io_pixel_y  out  CORDW  unsigned pixel row, 0..SCREEN_H-1.
- io_depth  out  CORDW  signed fixed-point z/w.
- io_clipped  out  1  point rejected (w <= 0).

Behaviour:
Reset:
- Asserting io_aresetn low immediately forces the FSM to IDLE.
- All outputs reset to 0 except io_ready, which resets to 1.
- A reset during a computation aborts it; no io_pixelValid pulse is produced for that point.

Handshake:
- At a rising edge with io_writeEnable=1 and io_ready=1, all four inputs are registered and the FSM leaves IDLE.
- io_writeEnable is ignored while io_ready=0.

FSM:
- IDLE -> DIVIDE on accept.
- DIVIDE lasts exactly CORDW+FRAC cycles.
- DIVIDE -> MAP (1 cycle) -> DONE (1 cycle) -> IDLE.
- Outputs are registered on entry to DONE. io_pixelValid=1 only during DONE.
- Latency: io_pixelValid is high CORDW+FRAC+2 cycles after the accept edge (26 cycles at defaults). Throughput is one point per CORDW+FRAC+3 cycles.
- Outputs hold their values until the next DONE or reset.

Divide:
- Three parallel radix-2 restoring dividers compute q = (num << FRAC) / w.
- Sign handled by sign-magnitude; quotient truncates toward zero.
- Results saturate to the signed CORDW range.

Clip:
- If w <= 0 (including w = 0), set io_clipped=1, io_pixel_x=0, io_pixel_y=0, io_depth=0.
- Timing is identical to the normal case.

Viewport transform (MAP):
- px = SCREEN_W/2 + ((ndc_x * SCREEN_W/2) >>> FRAC)
- py = SCREEN_H/2 - ((ndc_y * SCREEN_H/2) >>> FRAC), so y points down on screen.
- Use full-width products; >>> is an arithmetic shift (rounds toward -inf).
- Clamp px to [0, SCREEN_W-1] and py to [0, SCREEN_H-1].
- io_depth = ndc_z, unclamped.

Decomposition:
Shared package gfx_pkg:
- CORDW, FRAC, SCREEN_W, SCREEN_H defaults.
- Typedefs coord_t (signed CORDW) and pixel_t (unsigned CORDW).
- FSM state enum {IDLE, DIVIDE, MAP, DONE}.
- Constant ONE = 1 << FRAC.

Sub-module fixed_div:
- Sequential signed fixed-point divider with start input, CORDW+FRAC-cycle latency, and saturation.
- Instantiated three times, for x, y and z.

Test Plan:
1. Reset with io_aresetn=0 -> io_ready=1; io_pixelValid, io_pixel_x, io_pixel_y, io_clipped all 0.
2. Point (0,0,0,256) -> after 26 cycles, io_pixelValid pulse; pixel (320,240), io_depth=0, io_clipped=0. Raw w=1 gives the same pixel.
3. Point (128,128,128,256) -> ndc (0.5,0.5); pixel (480,120), io_depth=128. Point (-512,0,0,1024) -> pixel (160,240).
4. Point (256,-256,0,256) -> ndc (1,-1); pixel clamps to (639,479). Point (-2560,2560,0,256) -> (0,0), io_clipped=0.
5. Points with w=0 and with w=-256 -> io_clipped=1; pixel (0,0); io_depth=0; io_pixelValid still pulses at cycle 26.
6. Second io_writeEnable issued 5 cycles after the first accept -> ignored; exactly one io_pixelValid pulse. Separately, drop io_aresetn at cycle 10 -> no pulse, io_ready=1 immediately.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline constants, coordinate types and the normalizer FSM states.
package gfx_pkg;

  localparam int CORDW    = 16;
  localparam int FRAC     = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ONE      = 1 << FRAC;

  typedef logic signed [CORDW-1:0] coord_t;
  typedef logic        [CORDW-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    MAP,
    DONE
  } state_t;

endpackage

// File: rtl/point_normalizer_fixed_div.sv
// Sequential signed fixed-point divider: q = (num << FRAC) / den, one quotient bit
// per cycle, sign-magnitude, truncating toward zero and saturating to CORDW bits.
module fixed_div #(
  parameter int CORDW = 16,
  parameter int FRAC  = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CORDW-1:0] num,
  input  logic [CORDW-1:0] den,
  output logic [CORDW-1:0] q
);

  localparam int N    = CORDW + FRAC;
  localparam int CNTW = $clog2(N + 1);
  localparam logic [N-1:0] POS_MAX = N'((1 << (CORDW - 1)) - 1);
  localparam logic [N-1:0] NEG_MAX = N'(1 << (CORDW - 1));

  logic [N-1:0]     dvd, dvd_nxt;
  logic [CORDW-1:0] rem, rem_nxt, dsr, diff;
  logic [CORDW:0]   shifted;
  logic [CORDW-1:0] num_mag, den_mag;
  logic [CNTW-1:0]  cnt;
  logic             neg, ge;

  assign num_mag = num[CORDW-1] ? (~num + 1'b1) : num;
  assign den_mag = den[CORDW-1] ? (~den + 1'b1) : den;

  // The true difference is always below the divisor, so modulo-2^CORDW subtraction is exact.
  always_comb begin
    shifted = {rem, dvd[N-1]};
    ge      = (shifted >= {1'b0, dsr});
    diff    = shifted[CORDW-1:0] - dsr;
    rem_nxt = ge ? diff : shifted[CORDW-1:0];
    dvd_nxt = {dvd[N-2:0], ge};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      rem <= '0;
      dsr <= '0;
      neg <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      dvd <= {num_mag, {FRAC{1'b0}}};
      rem <= '0;
      dsr <= den_mag;
      neg <= num[CORDW-1] ^ den[CORDW-1];
      cnt <= CNTW'(N);
    end else if (cnt != '0) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    q = dvd[CORDW-1:0];
    if (neg) begin
      if (dvd > NEG_MAX) q = NEG_MAX[CORDW-1:0];
      else               q = ~dvd[CORDW-1:0] + 1'b1;
    end else if (dvd > POS_MAX) begin
      q = POS_MAX[CORDW-1:0];
    end
  end

endmodule

// File: rtl/point_normalizer.sv
// Perspective divide of a clip-space point followed by the viewport transform onto
// the raster; one point in flight, result announced by a single-cycle valid pulse.
module point_normalizer #(
  parameter int CORDW    = gfx_pkg::CORDW,
  parameter int FRAC     = gfx_pkg::FRAC,
  parameter int SCREEN_W = gfx_pkg::SCREEN_W,
  parameter int SCREEN_H = gfx_pkg::SCREEN_H
) (
  input  logic             clock,
  input  logic             io_aresetn,
  input  logic             io_writeEnable,
  input  logic [CORDW-1:0] io_point_x,
  input  logic [CORDW-1:0] io_point_y,
  input  logic [CORDW-1:0] io_point_z,
  input  logic [CORDW-1:0] io_point_w,
  output logic             io_ready,
  output logic             io_pixelValid,
  output logic [CORDW-1:0] io_pixel_x,
  output logic [CORDW-1:0] io_pixel_y,
  output logic [CORDW-1:0] io_depth,
  output logic             io_clipped
);

  import gfx_pkg::*;

  localparam int DIV_CYCLES = CORDW + FRAC;
  localparam int CNTW       = $clog2(DIV_CYCLES);
  localparam int MW         = 2 * CORDW + 2;
  localparam logic signed [MW-1:0] HALF_W = MW'(SCREEN_W / 2);
  localparam logic signed [MW-1:0] HALF_H = MW'(SCREEN_H / 2);
  localparam logic signed [MW-1:0] MAX_X  = MW'(SCREEN_W - 1);
  localparam logic signed [MW-1:0] MAX_Y  = MW'(SCREEN_H - 1);

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt;
  logic              clip_q;
  logic              accept;
  logic [CORDW-1:0]  q_x, q_y, q_z;
  logic signed [MW-1:0] ndc_x, ndc_y, prod_x, prod_y, px_full, py_full;
  logic [CORDW-1:0]  px_clamp, py_clamp;

  assign accept        = io_writeEnable && (state == IDLE);
  assign io_ready      = (state == IDLE);
  assign io_pixelValid = (state == DONE);

  fixed_div #(.CORDW(CORDW), .FRAC(FRAC)) u_div_x (
    .clock(clock), .rst_n(io_aresetn), .start(accept),
    .num(io_point_x), .den(io_point_w), .q(q_x)
  );
  fixed_div #(.CORDW(CORDW), .FRAC(FRAC)) u_div_y (
    .clock(clock), .rst_n(io_aresetn), .start(accept),
    .num(io_point_y), .den(io_point_w), .q(q_y)
  );
  fixed_div #(.CORDW(CORDW), .FRAC(FRAC)) u_div_z (
    .clock(clock), .rst_n(io_aresetn), .start(accept),
    .num(io_point_z), .den(io_point_w), .q(q_z)
  );

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) state <= IDLE;
    else             state <= state_nxt;
  end

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      cnt    <= '0;
      clip_q <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      clip_q <= io_point_w[CORDW-1] || (io_point_w == '0);
    end else if (state == DIVIDE) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DIVIDE;
      DIVIDE:  if (cnt == CNTW'(DIV_CYCLES - 1)) state_nxt = MAP;
      MAP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Viewport transform; the arithmetic shift floors, and y is flipped so rows grow downward.
  always_comb begin
    ndc_x   = {{(MW-CORDW){q_x[CORDW-1]}}, q_x};
    ndc_y   = {{(MW-CORDW){q_y[CORDW-1]}}, q_y};
    prod_x  = ndc_x * HALF_W;
    prod_y  = ndc_y * HALF_H;
    px_full = HALF_W + (prod_x >>> FRAC);
    py_full = HALF_H - (prod_y >>> FRAC);

    if (px_full < 0)          px_clamp = '0;
    else if (px_full > MAX_X) px_clamp = MAX_X[CORDW-1:0];
    else                      px_clamp = px_full[CORDW-1:0];

    if (py_full < 0)          py_clamp = '0;
    else if (py_full > MAX_Y) py_clamp = MAX_Y[CORDW-1:0];
    else                      py_clamp = py_full[CORDW-1:0];
  end

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      io_pixel_x <= '0;
      io_pixel_y <= '0;
      io_depth   <= '0;
      io_clipped <= 1'b0;
    end else if (state == MAP) begin
      io_clipped <= clip_q;
      io_pixel_x <= clip_q ? '0 : px_clamp;
      io_pixel_y <= clip_q ? '0 : py_clamp;
      io_depth   <= clip_q ? '0 : q_z;
    end
  end

endmodule

// File: tb/tb_point_normalizer.sv
// Directed bench for point_normalizer: expected pixels are queued at accept time from
// an integer reference model and popped when the valid pulse arrives.
module tb_point_normalizer;

  logic        clock = 1'b0;
  logic        io_aresetn;
  logic        io_writeEnable;
  logic [15:0] io_point_x, io_point_y, io_point_z, io_point_w;
  logic        io_ready, io_pixelValid, io_clipped;
  logic [15:0] io_pixel_x, io_pixel_y, io_depth;

  typedef struct {
    int px;
    int py;
    int depth;
    int clipped;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  point_normalizer dut (
    .clock(clock),
    .io_aresetn(io_aresetn),
    .io_writeEnable(io_writeEnable),
    .io_point_x(io_point_x),
    .io_point_y(io_point_y),
    .io_point_z(io_point_z),
    .io_point_w(io_point_w),
    .io_ready(io_ready),
    .io_pixelValid(io_pixelValid),
    .io_pixel_x(io_pixel_x),
    .io_pixel_y(io_pixel_y),
    .io_depth(io_depth),
    .io_clipped(io_clipped)
  );

  task automatic checkVal(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int div_ref(input int n, input int w);
    longint an, aw, q;
    an = (n < 0) ? -longint'(n) : longint'(n);
    aw = (w < 0) ? -longint'(w) : longint'(w);
    q  = (an * 256) / aw;
    if ((n < 0) != (w < 0)) q = -q;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int floor256(input longint p);
    if (p < 0 && (p % 256) != 0) return int'(p / 256 - 1);
    return int'(p / 256);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic exp_t model(input int x, input int y, input int z, input int w);
    exp_t e;
    int nx, ny;
    if (w <= 0) begin
      e.px = 0; e.py = 0; e.depth = 0; e.clipped = 1;
    end else begin
      nx = div_ref(x, w);
      ny = div_ref(y, w);
      e.px      = clampi(320 + floor256(longint'(nx) * 320), 0, 639);
      e.py      = clampi(240 - floor256(longint'(ny) * 240), 0, 479);
      e.depth   = div_ref(z, w);
      e.clipped = 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    e = sb.pop_front();
    checkVal({tag, "_px"},      int'(io_pixel_x), e.px);
    checkVal({tag, "_py"},      int'(io_pixel_y), e.py);
    checkVal({tag, "_depth"},   int'($signed(io_depth)), e.depth);
    checkVal({tag, "_clipped"}, int'(io_clipped), e.clipped);
  endtask

  // inject_at > 0 raises a second write request that many cycles after the accept.
  task automatic applyStimulus(input string tag, input int x, input int y, input int z,
                               input int w, input int inject_at);
    int lat;
    lat = 0;
    @(negedge clock);
    checkVal({tag, "_ready"}, int'(io_ready), 1);
    io_point_x = 16'(x); io_point_y = 16'(y); io_point_z = 16'(z); io_point_w = 16'(w);
    io_writeEnable = 1'b1;
    sb.push_back(model(x, y, z, w));
    @(negedge clock);
    io_writeEnable = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clock);
      if (inject_at != 0 && k == inject_at) begin
        io_point_x = 16'd2560; io_point_y = 16'd2560; io_point_z = 16'd77; io_point_w = 16'd256;
        io_writeEnable = 1'b1;
      end
      if (inject_at != 0 && k == inject_at + 1) io_writeEnable = 1'b0;
      if (io_pixelValid) begin
        lat = k;
        break;
      end
    end
    checkVal({tag, "_latency"}, lat, 26);
    if (lat != 0) checkOutput(tag);
    else void'(sb.pop_front());
    @(negedge clock);
    checkVal({tag, "_pulse_end"}, int'(io_pixelValid), 0);
    checkVal({tag, "_ready_after"}, int'(io_ready), 1);
  endtask

  initial begin
    int pulses;
    io_aresetn     = 1'b0;
    io_writeEnable = 1'b0;
    io_point_x = '0; io_point_y = '0; io_point_z = '0; io_point_w = '0;
    repeat (3) @(negedge clock);
    checkVal("rst_ready", int'(io_ready), 1);
    checkVal("rst_valid", int'(io_pixelValid), 0);
    checkVal("rst_px", int'(io_pixel_x), 0);
    checkVal("rst_py", int'(io_pixel_y), 0);
    checkVal("rst_clipped", int'(io_clipped), 0);
    checkVal("rst_depth", int'(io_depth), 0);
    io_aresetn = 1'b1;

    applyStimulus("origin",      0,     0,    0,    256, 0);
    applyStimulus("origin_w1",   0,     0,    0,    1,   0);
    applyStimulus("half",        128,   128,  128,  256, 0);
    applyStimulus("neg_quarter", -512,  0,    0,    1024, 0);
    applyStimulus("edge_clamp",  256,   -256, 0,    256, 0);
    applyStimulus("far_clamp",   -2560, 2560, 0,    256, 0);
    applyStimulus("clip_w0",     100,   100,  100,  0,   0);
    applyStimulus("clip_wneg",   100,   100,  100,  -256, 0);
    applyStimulus("trunc_pos",   100,   100,  -100, 768, 0);
    applyStimulus("trunc_neg",   -100,  -100, 100,  768, 0);
    applyStimulus("sat_pos",     256,   256,  256,  1,   0);
    applyStimulus("sat_neg",     -32768, 0,   -32768, 1, 0);

    applyStimulus("ignored_we",  128,   128,  128,  256, 5);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (io_pixelValid) pulses++;
    end
    checkVal("ignored_we_extra_pulses", pulses, 0);

    @(negedge clock);
    io_point_x = 16'd128; io_point_y = 16'd128; io_point_z = 16'd128; io_point_w = 16'd256;
    io_writeEnable = 1'b1;
    @(negedge clock);
    io_writeEnable = 1'b0;
    repeat (9) @(negedge clock);
    checkVal("abort_busy", int'(io_ready), 0);
    io_aresetn = 1'b0;
    #1;
    checkVal("abort_ready", int'(io_ready), 1);
    checkVal("abort_valid", int'(io_pixelValid), 0);
    checkVal("abort_px", int'(io_pixel_x), 0);
    @(negedge clock);
    io_aresetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (io_pixelValid) pulses++;
    end
    checkVal("abort_pulses", pulses, 0);

    applyStimulus("post_abort", 128, -128, 64, 256, 0);
    checkVal("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
